// File: rtl/sbox_column_scheduler.sv
// sbox_column_scheduler
// Time-shares one combinational 32-bit S-box column between two requesters.
// The round datapath's SubBytes needs four column passes over the 128-bit state.
// The key schedule's SubWord needs one pass over a single word.
// A key lookup happens in its own handshake cycle. When it lands while the state
// engine is running, it takes that cycle's S-box slot and the current column
// simply waits one cycle.
module sbox_column_scheduler #(
    parameter int KEY_PRIORITY = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         st_valid,
    output logic         st_ready,
    input  logic [127:0] st_in,
    output logic         st_out_valid,
    input  logic         st_out_ready,
    output logic [127:0] st_out,
    input  logic         kw_valid,
    output logic         kw_ready,
    input  logic [31:0]  kw_in,
    output logic         kw_out_valid,
    input  logic         kw_out_ready,
    output logic [31:0]  kw_out,
    output logic [31:0]  sb_in,
    input  logic [31:0]  sb_out
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]   state_q, state_d;
    logic [1:0]   col_q, col_d;
    logic [127:0] st_buf_q, st_buf_d;
    logic [127:0] st_res_q, st_res_d;
    logic         st_out_valid_q, st_out_valid_d;
    logic [31:0]  kw_out_q, kw_out_d;
    logic         kw_out_valid_q, kw_out_valid_d;

    logic         key_open;
    logic         kw_grant;
    logic         st_accept;
    logic         col_step;
    logic [31:0]  cur_column;

    // Handshake readiness.
    // Readies are forced low while reset is asserted so that nothing is granted
    // and the S-box input stays at zero.
    // A held key result always blocks new key requests.
    always_comb begin
        key_open  = (KEY_PRIORITY != 0) ? 1'b1 : (state_q != ST_RUN);
        kw_ready  = rst_n && !kw_out_valid_q && key_open;
        st_ready  = rst_n && (state_q == ST_IDLE);
        kw_grant  = kw_valid && kw_ready;
        st_accept = st_valid && st_ready;
        col_step  = (state_q == ST_RUN) && !kw_grant;
    end

    // Pick the buffered state column addressed by the column counter.
    // Column 0 is the most significant word.
    always_comb begin
        case (col_q)
            2'd0:    cur_column = st_buf_q[127:96];
            2'd1:    cur_column = st_buf_q[95:64];
            2'd2:    cur_column = st_buf_q[63:32];
            default: cur_column = st_buf_q[31:0];
        endcase
    end

    // Shared S-box input mux.
    // A granted key word wins; otherwise the running column is presented; otherwise zero.
    always_comb begin
        sb_in = 32'h0;
        if (kw_grant) begin
            sb_in = kw_in;
        end else if (state_q == ST_RUN) begin
            sb_in = cur_column;
        end
    end

    // State engine next-state logic.
    // Load the buffer, substitute one column per free cycle, then hold the result until it is consumed.
    always_comb begin
        state_d        = state_q;
        col_d          = col_q;
        st_buf_d       = st_buf_q;
        st_res_d       = st_res_q;
        st_out_valid_d = st_out_valid_q;
        case (state_q)
            ST_IDLE: begin
                if (st_accept) begin
                    state_d  = ST_RUN;
                    col_d    = 2'd0;
                    st_buf_d = st_in;
                end
            end
            ST_RUN: begin
                if (col_step) begin
                    case (col_q)
                        2'd0:    st_res_d[127:96] = sb_out;
                        2'd1:    st_res_d[95:64]  = sb_out;
                        2'd2:    st_res_d[63:32]  = sb_out;
                        default: st_res_d[31:0]   = sb_out;
                    endcase
                    col_d = col_q + 2'd1;
                    if (col_q == 2'd3) begin
                        state_d        = ST_DONE;
                        st_out_valid_d = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                if (st_out_ready) begin
                    state_d        = ST_IDLE;
                    st_out_valid_d = 1'b0;
                end
            end
            default: begin
                state_d        = ST_IDLE;
                col_d          = 2'd0;
                st_out_valid_d = 1'b0;
            end
        endcase
    end

    // Key path next-state logic.
    // The S-box result is captured at the grant edge and held until consumed.
    always_comb begin
        kw_out_d       = kw_out_q;
        kw_out_valid_d = kw_out_valid_q;
        if (kw_grant) begin
            kw_out_d       = sb_out;
            kw_out_valid_d = 1'b1;
        end else if (kw_out_valid_q && kw_out_ready) begin
            kw_out_valid_d = 1'b0;
        end
    end

    // State registers with asynchronous reset.
    // Reset discards any in-flight work.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            col_q          <= 2'd0;
            st_buf_q       <= 128'h0;
            st_res_q       <= 128'h0;
            st_out_valid_q <= 1'b0;
            kw_out_q       <= 32'h0;
            kw_out_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            col_q          <= col_d;
            st_buf_q       <= st_buf_d;
            st_res_q       <= st_res_d;
            st_out_valid_q <= st_out_valid_d;
            kw_out_q       <= kw_out_d;
            kw_out_valid_q <= kw_out_valid_d;
        end
    end

    assign st_out       = st_res_q;
    assign st_out_valid = st_out_valid_q;
    assign kw_out       = kw_out_q;
    assign kw_out_valid = kw_out_valid_q;

endmodule

// File: tb/tb_sbox_column_scheduler.sv
// Testbench for sbox_column_scheduler.
// Two instances share the stimulus: one preempting (KEY_PRIORITY=1) and one blocking (KEY_PRIORITY=0).
// The AES S-box is built from GF(2^8) inversion plus the affine map.
// Expected results come from applying that table byte by byte.
`timescale 1ns/1ps
module tb_sbox_column_scheduler;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         st_valid;
    logic [127:0] st_in;
    logic         st_out_ready;
    logic         kw_valid;
    logic [31:0]  kw_in;
    logic         kw_out_ready;

    logic         st_ready, st_out_valid, kw_ready, kw_out_valid;
    logic [127:0] st_out;
    logic [31:0]  kw_out, sb_in, sb_out;

    logic         st_ready_0, st_out_valid_0, kw_ready_0, kw_out_valid_0;
    logic [127:0] st_out_0;
    logic [31:0]  kw_out_0, sb_in_0, sb_out_0;

    logic [7:0]   sbox_tab [256];
    int           checks;
    int           errors;

    localparam logic [127:0] VEC1 = 128'h00000101030307070f0f1f1f3f3f6f8f;
    localparam logic [127:0] EXP1 = 128'h63637c7c7b7bc5c57676c0c07575a873;
    localparam logic [127:0] VEC2 = 128'h0c2c341c9ca0fe14c90d2881a92d7721;
    localparam logic [127:0] EXP2 = 128'hfe71189cdee0bbfaddd7340cd3d8f5fd;
    localparam logic [31:0]  KW1  = 32'hcf4f3c09;
    localparam logic [31:0]  KEXP = 32'h8a84eb01;

    always #5 clk = ~clk;

    sbox_column_scheduler #(.KEY_PRIORITY(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .st_valid(st_valid), .st_ready(st_ready), .st_in(st_in),
        .st_out_valid(st_out_valid), .st_out_ready(st_out_ready), .st_out(st_out),
        .kw_valid(kw_valid), .kw_ready(kw_ready), .kw_in(kw_in),
        .kw_out_valid(kw_out_valid), .kw_out_ready(kw_out_ready), .kw_out(kw_out),
        .sb_in(sb_in), .sb_out(sb_out)
    );

    sbox_column_scheduler #(.KEY_PRIORITY(0)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .st_valid(st_valid), .st_ready(st_ready_0), .st_in(st_in),
        .st_out_valid(st_out_valid_0), .st_out_ready(st_out_ready), .st_out(st_out_0),
        .kw_valid(kw_valid), .kw_ready(kw_ready_0), .kw_in(kw_in),
        .kw_out_valid(kw_out_valid_0), .kw_out_ready(kw_out_ready), .kw_out(kw_out_0),
        .sb_in(sb_in_0), .sb_out(sb_out_0)
    );

    assign sb_out   = {sbox_tab[sb_in[31:24]], sbox_tab[sb_in[23:16]],
                       sbox_tab[sb_in[15:8]],  sbox_tab[sb_in[7:0]]};
    assign sb_out_0 = {sbox_tab[sb_in_0[31:24]], sbox_tab[sb_in_0[23:16]],
                       sbox_tab[sb_in_0[15:8]],  sbox_tab[sb_in_0[7:0]]};

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] gf_sbox(input logic [7:0] a);
        logic [7:0] inv;
        inv = 8'h01;
        for (int i = 0; i < 254; i++) inv = gmul(inv, a);
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
               {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox_tab[w[31:24]], sbox_tab[w[23:16]], sbox_tab[w[15:8]], sbox_tab[w[7:0]]};
    endfunction

    function automatic logic [127:0] sub_state(input logic [127:0] s);
        logic [127:0] r;
        r = '0;
        for (int b = 0; b < 16; b++) r[8*b +: 8] = sbox_tab[s[8*b +: 8]];
        return r;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        st_valid = 1'b0; st_in = '0; st_out_ready = 1'b0;
        kw_valid = 1'b0; kw_in = '0; kw_out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        st_valid = 1'b0; st_in = '0; st_out_ready = 1'b0;
        kw_valid = 1'b0; kw_in = '0; kw_out_ready = 1'b0;
        #2;
        checks++; if (st_out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_st_out_valid: got %b expected 0", st_out_valid); end
        checks++; if (kw_out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_kw_out_valid: got %b expected 0", kw_out_valid); end
        checks++; if (st_out !== 128'h0) begin errors++; $display("[TB] FAIL reset_st_out: got %h expected 0", st_out); end
        checks++; if (kw_out !== 32'h0) begin errors++; $display("[TB] FAIL reset_kw_out: got %h expected 0", kw_out); end
        checks++; if (sb_in !== 32'h0) begin errors++; $display("[TB] FAIL reset_sb_in: got %h expected 0", sb_in); end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        checks++; if (st_ready !== 1'b1) begin errors++; $display("[TB] FAIL release_st_ready: got %b expected 1", st_ready); end
        checks++; if (kw_ready !== 1'b1) begin errors++; $display("[TB] FAIL release_kw_ready: got %b expected 1", kw_ready); end
        checks++; if (kw_ready_0 !== 1'b1) begin errors++; $display("[TB] FAIL release_kw_ready_kp0: got %b expected 1", kw_ready_0); end
        checks++; if (st_out_valid !== 1'b0) begin errors++; $display("[TB] FAIL release_st_out_valid: got %b expected 0", st_out_valid); end
    endtask

    task automatic test_state_only();
        int lat;
        do_reset();
        st_in = VEC1; st_valid = 1'b1; #1;
        checks++; if (st_ready !== 1'b1) begin errors++; $display("[TB] FAIL so_st_ready: got %b expected 1", st_ready); end
        @(posedge clk); #1;
        st_valid = 1'b0; st_in = rand128();
        lat = 1;
        while (st_out_valid !== 1'b1 && lat < 20) begin
            if (lat <= 4) begin
                checks++; if (sb_in !== VEC1[127-32*(lat-1) -: 32]) begin errors++; $display("[TB] FAIL so_sb_in_col%0d: got %h expected %h", lat-1, sb_in, VEC1[127-32*(lat-1) -: 32]); end
            end
            @(posedge clk); #1; lat++;
        end
        checks++; if (lat != 5) begin errors++; $display("[TB] FAIL so_latency: got %0d expected 5", lat); end
        checks++; if (st_out !== EXP1) begin errors++; $display("[TB] FAIL so_st_out: got %h expected %h", st_out, EXP1); end
        st_out_ready = 1'b1;
        @(posedge clk); #1;
        st_out_ready = 1'b0;
        checks++; if (st_out_valid !== 1'b0) begin errors++; $display("[TB] FAIL so_consume_valid: got %b expected 0", st_out_valid); end
        checks++; if (st_ready !== 1'b1) begin errors++; $display("[TB] FAIL so_consume_ready: got %b expected 1", st_ready); end
    endtask

    task automatic test_back_to_back();
        int lat;
        do_reset();
        st_in = VEC2; st_valid = 1'b1;
        @(posedge clk); #1;
        st_in = VEC1;
        lat = 1;
        while (st_out_valid !== 1'b1 && lat < 20) begin
            @(posedge clk); #1; lat++;
        end
        checks++; if (lat != 5) begin errors++; $display("[TB] FAIL b2b_latency1: got %0d expected 5", lat); end
        for (int i = 0; i < 3; i++) begin
            checks++; if (st_out !== EXP2) begin errors++; $display("[TB] FAIL b2b_stall_out%0d: got %h expected %h", i, st_out, EXP2); end
            checks++; if (st_ready !== 1'b0 || st_out_valid !== 1'b1) begin errors++; $display("[TB] FAIL b2b_stall_flags%0d: got ready=%b valid=%b expected ready=0 valid=1", i, st_ready, st_out_valid); end
            @(posedge clk); #1;
        end
        st_out_ready = 1'b1; #1;
        checks++; if (st_ready !== 1'b0) begin errors++; $display("[TB] FAIL b2b_consume_ready: got %b expected 0", st_ready); end
        @(posedge clk); #1;
        st_out_ready = 1'b0;
        checks++; if (st_out_valid !== 1'b0 || st_ready !== 1'b1) begin errors++; $display("[TB] FAIL b2b_after_consume: got valid=%b ready=%b expected valid=0 ready=1", st_out_valid, st_ready); end
        @(posedge clk); #1;
        st_valid = 1'b0; st_in = rand128();
        lat = 1;
        while (st_out_valid !== 1'b1 && lat < 20) begin
            @(posedge clk); #1; lat++;
        end
        checks++; if (lat != 5) begin errors++; $display("[TB] FAIL b2b_latency2: got %0d expected 5", lat); end
        checks++; if (st_out !== EXP1) begin errors++; $display("[TB] FAIL b2b_st_out2: got %h expected %h", st_out, EXP1); end
        st_out_ready = 1'b1;
        @(posedge clk); #1;
        st_out_ready = 1'b0;
    endtask

    task automatic test_key_only();
        do_reset();
        kw_in = KW1; kw_valid = 1'b1; #1;
        checks++; if (kw_ready !== 1'b1) begin errors++; $display("[TB] FAIL ko_kw_ready: got %b expected 1", kw_ready); end
        checks++; if (sb_in !== KW1) begin errors++; $display("[TB] FAIL ko_sb_in: got %h expected %h", sb_in, KW1); end
        @(posedge clk); #1;
        kw_in = $urandom;
        checks++; if (kw_out_valid !== 1'b1) begin errors++; $display("[TB] FAIL ko_kw_out_valid: got %b expected 1", kw_out_valid); end
        checks++; if (kw_out !== KEXP) begin errors++; $display("[TB] FAIL ko_kw_out: got %h expected %h", kw_out, KEXP); end
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++; if (kw_ready !== 1'b0) begin errors++; $display("[TB] FAIL ko_held_ready%0d: got %b expected 0", i, kw_ready); end
            @(posedge clk); #1;
            checks++; if (kw_out !== KEXP || kw_out_valid !== 1'b1) begin errors++; $display("[TB] FAIL ko_held_out%0d: got %h/%b expected %h/1", i, kw_out, kw_out_valid, KEXP); end
        end
        kw_out_ready = 1'b1; #1;
        checks++; if (kw_ready !== 1'b0) begin errors++; $display("[TB] FAIL ko_consume_ready: got %b expected 0", kw_ready); end
        @(posedge clk); #1;
        kw_out_ready = 1'b0; kw_valid = 1'b0; #1;
        checks++; if (kw_out_valid !== 1'b0) begin errors++; $display("[TB] FAIL ko_consumed_valid: got %b expected 0", kw_out_valid); end
        checks++; if (kw_ready !== 1'b1) begin errors++; $display("[TB] FAIL ko_consumed_ready: got %b expected 1", kw_ready); end
        checks++; if (sb_in !== 32'h0) begin errors++; $display("[TB] FAIL ko_idle_sb_in: got %h expected 0", sb_in); end
    endtask

    task automatic test_preempt();
        int lat;
        int cols;
        do_reset();
        st_in = VEC1; st_valid = 1'b1;
        @(posedge clk); #1;
        st_valid = 1'b0;
        lat = 1; cols = 0;
        while (st_out_valid !== 1'b1 && lat < 20) begin
            if (lat == 3) begin
                kw_in = KW1; kw_valid = 1'b1; #1;
                checks++; if (kw_ready !== 1'b1) begin errors++; $display("[TB] FAIL pre_kw_ready: got %b expected 1", kw_ready); end
                checks++; if (sb_in !== KW1) begin errors++; $display("[TB] FAIL pre_sb_in_key: got %h expected %h", sb_in, KW1); end
            end else if (cols < 4) begin
                checks++; if (sb_in !== VEC1[127-32*cols -: 32]) begin errors++; $display("[TB] FAIL pre_sb_in_col%0d: got %h expected %h", cols, sb_in, VEC1[127-32*cols -: 32]); end
                cols++;
            end
            @(posedge clk); #1;
            kw_valid = 1'b0;
            lat++;
        end
        checks++; if (lat != 6) begin errors++; $display("[TB] FAIL pre_latency: got %0d expected 6", lat); end
        checks++; if (st_out !== EXP1) begin errors++; $display("[TB] FAIL pre_st_out: got %h expected %h", st_out, EXP1); end
        checks++; if (kw_out_valid !== 1'b1 || kw_out !== KEXP) begin errors++; $display("[TB] FAIL pre_kw_out: got %h/%b expected %h/1", kw_out, kw_out_valid, KEXP); end
        st_out_ready = 1'b1; kw_out_ready = 1'b1;
        @(posedge clk); #1;
        st_out_ready = 1'b0; kw_out_ready = 1'b0;
    endtask

    task automatic test_key_blocked();
        int lat;
        do_reset();
        st_in = VEC2; st_valid = 1'b1; #1;
        checks++; if (st_ready_0 !== 1'b1) begin errors++; $display("[TB] FAIL kb_st_ready: got %b expected 1", st_ready_0); end
        @(posedge clk); #1;
        st_valid = 1'b0; kw_valid = 1'b1; kw_in = KW1;
        lat = 1;
        while (st_out_valid_0 !== 1'b1 && lat < 20) begin
            #1;
            checks++; if (kw_ready_0 !== 1'b0) begin errors++; $display("[TB] FAIL kb_run_ready_cyc%0d: got %b expected 0", lat, kw_ready_0); end
            checks++; if (kw_out_valid_0 !== 1'b0) begin errors++; $display("[TB] FAIL kb_run_kvalid_cyc%0d: got %b expected 0", lat, kw_out_valid_0); end
            @(posedge clk); #1; lat++;
        end
        checks++; if (lat != 5) begin errors++; $display("[TB] FAIL kb_latency: got %0d expected 5", lat); end
        checks++; if (st_out_0 !== EXP2) begin errors++; $display("[TB] FAIL kb_st_out: got %h expected %h", st_out_0, EXP2); end
        #1;
        checks++; if (kw_ready_0 !== 1'b1) begin errors++; $display("[TB] FAIL kb_done_ready: got %b expected 1", kw_ready_0); end
        @(posedge clk); #1;
        kw_valid = 1'b0;
        checks++; if (kw_out_valid_0 !== 1'b1 || kw_out_0 !== KEXP) begin errors++; $display("[TB] FAIL kb_kw_out: got %h/%b expected %h/1", kw_out_0, kw_out_valid_0, KEXP); end
        st_out_ready = 1'b1; kw_out_ready = 1'b1;
        @(posedge clk); #1;
        st_out_ready = 1'b0; kw_out_ready = 1'b0;
        checks++; if (st_out_valid_0 !== 1'b0 || kw_out_valid_0 !== 1'b0) begin errors++; $display("[TB] FAIL kb_consumed: got st=%b kw=%b expected 0/0", st_out_valid_0, kw_out_valid_0); end
    endtask

    task automatic test_reset_midrun();
        int lat;
        logic [127:0] v;
        do_reset();
        kw_in = $urandom; kw_valid = 1'b1;
        @(posedge clk); #1;
        kw_valid = 1'b0;
        st_in = VEC1; st_valid = 1'b1;
        @(posedge clk); #1;
        st_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0; #1;
        checks++; if (st_out_valid !== 1'b0 || kw_out_valid !== 1'b0) begin errors++; $display("[TB] FAIL rm_valids: got st=%b kw=%b expected 0/0", st_out_valid, kw_out_valid); end
        checks++; if (st_out !== 128'h0) begin errors++; $display("[TB] FAIL rm_st_out: got %h expected 0", st_out); end
        checks++; if (kw_out !== 32'h0) begin errors++; $display("[TB] FAIL rm_kw_out: got %h expected 0", kw_out); end
        checks++; if (sb_in !== 32'h0) begin errors++; $display("[TB] FAIL rm_sb_in: got %h expected 0", sb_in); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++; if (st_out_valid !== 1'b0 || st_ready !== 1'b1) begin errors++; $display("[TB] FAIL rm_release: got valid=%b ready=%b expected 0/1", st_out_valid, st_ready); end
        v = rand128();
        st_in = v; st_valid = 1'b1;
        @(posedge clk); #1;
        st_valid = 1'b0;
        lat = 1;
        while (st_out_valid !== 1'b1 && lat < 20) begin
            @(posedge clk); #1; lat++;
        end
        checks++; if (lat != 5) begin errors++; $display("[TB] FAIL rm_latency: got %0d expected 5", lat); end
        checks++; if (st_out !== sub_state(v)) begin errors++; $display("[TB] FAIL rm_st_out_fresh: got %h expected %h", st_out, sub_state(v)); end
        st_out_ready = 1'b1;
        @(posedge clk); #1;
        st_out_ready = 1'b0;
    endtask

    task automatic test_random();
        int lat;
        int grants;
        bit key_held;
        bit granted;
        logic [31:0] kexp;
        logic [31:0] kword;
        logic [127:0] v;
        do_reset();
        key_held = 1'b0;
        kexp = '0;
        for (int n = 0; n < 40; n++) begin
            v = rand128();
            st_in = v; st_valid = 1'b1; #1;
            checks++; if (st_ready !== 1'b1) begin errors++; $display("[TB] FAIL rnd_st_ready_t%0d: got %b expected 1", n, st_ready); end
            @(posedge clk); #1;
            st_valid = 1'b0; st_in = rand128();
            lat = 1; grants = 0;
            while (st_out_valid !== 1'b1 && lat < 30) begin
                checks++; if (kw_out_valid !== key_held) begin errors++; $display("[TB] FAIL rnd_kw_valid_t%0d: got %b expected %b", n, kw_out_valid, key_held); end
                if (key_held) begin
                    checks++; if (kw_out !== kexp) begin errors++; $display("[TB] FAIL rnd_kw_out_t%0d: got %h expected %h", n, kw_out, kexp); end
                end
                kword = $urandom;
                kw_in = kword;
                kw_valid = ($urandom_range(0, 2) == 0);
                kw_out_ready = key_held && ($urandom_range(0, 1) == 1);
                #1;
                checks++; if (kw_ready !== !key_held) begin errors++; $display("[TB] FAIL rnd_kw_ready_t%0d: got %b expected %b", n, kw_ready, !key_held); end
                granted = kw_valid && !key_held;
                if (granted) begin
                    checks++; if (sb_in !== kword) begin errors++; $display("[TB] FAIL rnd_sb_in_t%0d: got %h expected %h", n, sb_in, kword); end
                end
                @(posedge clk); #1;
                if (granted) begin
                    key_held = 1'b1;
                    kexp = sub_word(kword);
                    grants++;
                end else if (key_held && kw_out_ready) begin
                    key_held = 1'b0;
                end
                kw_valid = 1'b0; kw_out_ready = 1'b0;
                lat++;
            end
            checks++; if (lat != 5 + grants) begin errors++; $display("[TB] FAIL rnd_latency_t%0d: got %0d expected %0d", n, lat, 5 + grants); end
            checks++; if (st_out !== sub_state(v)) begin errors++; $display("[TB] FAIL rnd_st_out_t%0d: got %h expected %h", n, st_out, sub_state(v)); end
            st_out_ready = 1'b1;
            @(posedge clk); #1;
            st_out_ready = 1'b0;
        end
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        checks = 0;
        errors = 0;
        for (int i = 0; i < 256; i++) sbox_tab[i] = gf_sbox(8'(i));
        test_reset();
        test_state_only();
        test_back_to_back();
        test_key_only();
        test_preempt();
        test_key_blocked();
        test_reset_midrun();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
